// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths, register count and types for the MIPS register file
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 2 ** ADDR_W_DEF;
    localparam int ZERO_REG   = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - one combinational read port: decode/mux, r0 mask, optional write forwarding
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic                               byp_en,
    input  logic [ADDR_W-1:0]                  byp_addr,
    input  logic [DATA_W-1:0]                  byp_data,
    output logic [DATA_W-1:0]                  rdata
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    // Select stored word, let an in-flight write override it, then force r0 to zero last
    always_comb begin
        rdata = regs[addr];
        if (byp_en && (addr == byp_addr)) begin
            rdata = byp_data;
        end
        if (addr == ZERO_ADDR) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write register file with hardwired r0; REG_FILE_BYPASS_EN adds write-to-read forwarding
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] data3,
    output logic [DATA_W-1:0] rdout1,
    output logic [DATA_W-1:0] rdout2
);

    localparam int                NUM       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NUM-1:0][DATA_W-1:0] mem;
    logic                       byp_en;

`ifdef REG_FILE_BYPASS_EN
    // Forward only real writes; reset kills the path so outputs read zero while rst is high
    assign byp_en = wr && !rst && (addr3 != ZERO_ADDR);
`else
    assign byp_en = 1'b0;
`endif

    // Reset clears the whole array at once; writes to r0 are dropped so it never holds data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (wr && (addr3 != ZERO_ADDR)) begin
            mem[addr3] <= data3;
        end
    end

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .regs     (mem),
        .addr     (addr1),
        .byp_en   (byp_en),
        .byp_addr (addr3),
        .byp_data (data3),
        .rdata    (rdout1)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .regs     (mem),
        .addr     (addr2),
        .byp_en   (byp_en),
        .byp_addr (addr3),
        .byp_data (data3),
        .rdata    (rdout2)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;
    import reg_file_pkg::*;

    logic      clk;
    logic      rst;
    logic      wr;
    reg_addr_t addr1;
    reg_addr_t addr2;
    reg_addr_t addr3;
    reg_data_t data3;
    reg_data_t rdout1;
    reg_data_t rdout2;

    int vectors;
    int miscompares;

    reg_file dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr),
        .addr1  (addr1),
        .addr2  (addr2),
        .addr3  (addr3),
        .data3  (data3),
        .rdout1 (rdout1),
        .rdout2 (rdout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input reg_data_t observed, input reg_data_t expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic do_write(input reg_addr_t a, input reg_data_t d);
        @(negedge clk);
        wr    = 1'b1;
        addr3 = a;
        data3 = d;
        @(posedge clk);
        #1;
        wr    = 1'b0;
    endtask

    initial begin
        reg_data_t byp_exp;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b0;
        wr    = 1'b0;
        addr1 = '0;
        addr2 = '0;
        addr3 = '0;
        data3 = '0;

        // reset pulse before the first rising edge, then sweep every address
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            addr1 = reg_addr_t'(i);
            addr2 = reg_addr_t'(NUM_REGS - 1 - i);
            #1;
            check("reset_sweep_p1", rdout1, 32'h0000_0000);
            check("reset_sweep_p2", rdout2, 32'h0000_0000);
        end

        // basic write/read
        do_write(5'd10, 32'h0000_FFFF);
        addr1 = 5'd10;
        #1 check("basic_r10", rdout1, 32'h0000_FFFF);

        // multiple registers
        do_write(5'd14, 32'h0000_FF00);
        do_write(5'd31, 32'h0000_AAAA);
        addr1 = 5'd31;
        addr2 = 5'd10;
        #1;
        check("multi_r31", rdout1, 32'h0000_AAAA);
        check("multi_r10", rdout2, 32'h0000_FFFF);
        addr1 = 5'd14;
        #1 check("multi_r14", rdout1, 32'h0000_FF00);

        // both ports on the same address
        addr1 = 5'd31;
        addr2 = 5'd31;
        #1;
        check("same_addr_p1", rdout1, 32'h0000_AAAA);
        check("same_addr_p2", rdout2, 32'h0000_AAAA);

        // simultaneous read/write of r1
        @(negedge clk);
        addr1 = 5'd14;
        addr2 = 5'd10;
        wr    = 1'b1;
        addr3 = 5'd1;
        data3 = 32'h0000_8888;
        #1;
        check("rw_cycle_r14", rdout1, 32'h0000_FF00);
        check("rw_cycle_r10", rdout2, 32'h0000_FFFF);
        addr1 = 5'd1;
`ifdef REG_FILE_BYPASS_EN
        byp_exp = 32'h0000_8888;
`else
        byp_exp = 32'h0000_0000;
`endif
        #1 check("rw_before_edge_r1", rdout1, byp_exp);
        @(posedge clk);
        #1;
        wr = 1'b0;
        check("rw_after_edge_r1", rdout1, 32'h0000_8888);
        check("rw_after_edge_r10", rdout2, 32'h0000_FFFF);
        addr1 = 5'd14;
        #1 check("rw_after_edge_r14", rdout1, 32'h0000_FF00);

        // wr=0 leaves storage untouched
        @(negedge clk);
        wr    = 1'b0;
        addr3 = 5'd14;
        data3 = 32'h1234_5678;
        @(posedge clk);
        #1 check("no_wr_r14", rdout1, 32'h0000_FF00);

        // writes to r0 are discarded, with no forwarding either
        @(negedge clk);
        addr1 = 5'd0;
        addr2 = 5'd0;
        wr    = 1'b1;
        addr3 = 5'd0;
        data3 = 32'hDEAD_BEEF;
        #1 check("zero_before_edge", rdout1, 32'h0000_0000);
        @(posedge clk);
        #1;
        wr = 1'b0;
        check("zero_p1", rdout1, 32'h0000_0000);
        check("zero_p2", rdout2, 32'h0000_0000);

        // overwrite an existing register
        do_write(5'd10, 32'h1234_5678);
        addr1 = 5'd10;
        #1 check("overwrite_r10", rdout1, 32'h1234_5678);

        // async reset between edges
        @(negedge clk);
        #2 rst = 1'b1;
        addr1 = 5'd10;
        addr2 = 5'd14;
        #1;
        check("async_rst_r10", rdout1, 32'h0000_0000);
        check("async_rst_r14", rdout2, 32'h0000_0000);
        addr1 = 5'd31;
        #1 check("async_rst_r31", rdout1, 32'h0000_0000);

        // rst dominates wr, and gates forwarding
        wr    = 1'b1;
        addr3 = 5'd5;
        data3 = 32'h0000_5555;
        addr1 = 5'd5;
        #1 check("rst_gates_fwd_r5", rdout1, 32'h0000_0000);
        @(posedge clk);
        #1 check("rst_blocks_wr_r5", rdout1, 32'h0000_0000);

        // release mid-cycle; the next edge commits the write
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        wr = 1'b0;
        check("post_rst_write_r5", rdout1, 32'h0000_5555);
        addr2 = 5'd10;
        #1 check("post_rst_r10_clear", rdout2, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
